voice_allocator: RTL and testbench

Polyphonic voice scheduler for the audio block. It accepts note-on/note-off events over a valid/ready handshake and assigns them to a bank of `VOICES` envelope-plus-amplifier voices. For each voice it drives a per-voice gate and note number, retriggering and stealing voices in least-recently-allocated order. It sits between the register/MIDI front end and the per-voice oscillator/envelope/amplifier chains, and runs in the system clock domain. It uses `sample_tick` to guarantee that every gate gap is visible to envelopes running at sample rate.

---
 rtl/voice_allocator.sv | 147 ++++++++++++++
 tb/tb_voice_allocator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler. Note-on/note-off events arrive over a
// valid/ready handshake and are mapped onto VOICES voices. Voices are
// reused in least-recently-allocated order. A retriggered or stolen voice
// has its gate held low until the next sample tick, so the envelope always
// sees the gap.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sample_tick       one-clk pulse per audio sample
//   ev_valid/ev_ready event handshake (ready only while idle)
//   ev_on, ev_note    event kind (1 = note-on) and note number
//   gate              per-voice envelope gate
//   voice_note        per-voice note, voice i at [i*NOTEBITS +: NOTEBITS]
//   stolen            one-cycle pulse when a held voice is stolen
//   last_voice        index of the voice touched by the latest event
module voice_allocator #(
  parameter int VOICES   = 4,
  parameter int NOTEBITS = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [NOTEBITS-1:0]        ev_note,
  output logic [VOICES-1:0]          gate,
  output logic [VOICES*NOTEBITS-1:0] voice_note,
  output logic                       stolen,
  output logic [2:0]                 last_voice
);

  typedef enum logic [1:0] {IDLE, DECIDE, GAP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          rank [VOICES];
  logic                on_q;
  logic [NOTEBITS-1:0] note_q;
  logic [2:0]          tgt_q;

  logic                match_found, free_found;
  logic [2:0]          match_idx, free_idx, free_rank, oldest_idx;
  logic [2:0]          tgt_idx, tgt_rank;
  logic                need_gap, is_steal;

  // Voice search: gated voice holding the note, the oldest free voice, and
  // the overall oldest voice (steal candidate).
  always_comb begin
    match_found = 1'b0;
    match_idx   = 3'd0;
    free_found  = 1'b0;
    free_idx    = 3'd0;
    free_rank   = 3'd0;
    oldest_idx  = 3'd0;
    for (int i = 0; i < VOICES; i++) begin
      if (gate[i] && (voice_note[i*NOTEBITS +: NOTEBITS] == note_q) && !match_found) begin
        match_found = 1'b1;
        match_idx   = 3'(i);
      end
      if (!gate[i] && (!free_found || (rank[i] > free_rank))) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
        free_rank  = rank[i];
      end
      if (rank[i] == 3'(VOICES-1)) oldest_idx = 3'(i);
    end
    if (match_found)     tgt_idx = match_idx;
    else if (free_found) tgt_idx = free_idx;
    else                 tgt_idx = oldest_idx;
    need_gap = match_found || !free_found;
    is_steal = !match_found && !free_found;
    tgt_rank = 3'd0;
    for (int i = 0; i < VOICES; i++) begin
      if (3'(i) == tgt_idx) tgt_rank = rank[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ev_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) state_d = DECIDE;
      end
      DECIDE:  state_d = (on_q && need_gap) ? GAP : IDLE;
      GAP:     if (sample_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Event latch and pending re-gate target; only meaningful while busy.
  always_ff @(posedge clk) begin
    if (ev_valid && ev_ready) begin
      on_q   <= ev_on;
      note_q <= ev_note;
    end
    if (state_q == DECIDE) tgt_q <= tgt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate       <= '0;
      voice_note <= '0;
      stolen     <= 1'b0;
      last_voice <= 3'd0;
      for (int i = 0; i < VOICES; i++) rank[i] <= 3'(VOICES-1-i);
    end else begin
      stolen <= 1'b0;
      if (state_q == DECIDE) begin
        if (!on_q) begin
          if (match_found) begin
            last_voice <= match_idx;
            for (int i = 0; i < VOICES; i++) begin
              if (3'(i) == match_idx) gate[i] <= 1'b0;
            end
          end
        end else begin
          last_voice <= tgt_idx;
          stolen     <= is_steal;
          // Target becomes newest; voices newer than it age by one.
          for (int i = 0; i < VOICES; i++) begin
            if (3'(i) == tgt_idx) begin
              voice_note[i*NOTEBITS +: NOTEBITS] <= note_q;
              gate[i] <= !need_gap;
              rank[i] <= 3'd0;
            end else if (rank[i] < tgt_rank) begin
              rank[i] <= rank[i] + 3'd1;
            end
          end
        end
      end
      if ((state_q == GAP) && sample_tick) begin
        for (int i = 0; i < VOICES; i++) begin
          if (3'(i) == tgt_q) gate[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed scenarios followed by random
// events, checked against an age-ordered list model of voice usage.
module tb_voice_allocator;
  localparam int V  = 4;
  localparam int NB = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_tick;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_on;
  logic [NB-1:0] ev_note;
  logic [V-1:0]  gate;
  logic [V*NB-1:0] voice_note;
  logic          stolen;
  logic [2:0]    last_voice;

  voice_allocator #(.VOICES(V), .NOTEBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_note(ev_note),
    .gate(gate), .voice_note(voice_note), .stolen(stolen), .last_voice(last_voice)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  // Model: per-voice gate/note plus a usage list, newest voice first.
  bit m_gate [V];
  int m_note [V];
  int m_last;
  int order[$];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    order.delete();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = 0;
    end
    for (int i = 0; i < V; i++) order.push_front(i);  // voice 0 oldest
    m_last = 0;
  endtask

  task automatic check_state(input string tag);
    logic [V-1:0]    eg;
    logic [V*NB-1:0] en;
    for (int i = 0; i < V; i++) begin
      eg[i] = m_gate[i];
      en[i*NB +: NB] = NB'(m_note[i]);
    end
    chk(32'(gate), 32'(eg), {tag, "_gate"});
    chk(32'(voice_note), 32'(en), {tag, "_note"});
    chk(32'(last_voice), 32'(m_last), {tag, "_last"});
  endtask

  // One complete event, called at a negedge with the allocator idle.
  task automatic send(input bit on, input int note, input bit tick_dec,
                      input int gap_wait, input bit abort);
    int tgt;
    int pos;
    bit gap;
    bit steal;
    chk(32'(ev_ready), 1, "ready_idle");
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = NB'(note);
    @(negedge clk);
    chk(32'(ev_ready), 0, "ready_accepted");
    sample_tick = tick_dec;
    @(negedge clk);
    sample_tick = 1'b0;
    gap = 1'b0; steal = 1'b0; tgt = -1; pos = 0;
    for (int i = 0; i < V; i++) if (m_gate[i] && m_note[i] == note) tgt = i;
    if (!on) begin
      if (tgt >= 0) begin
        m_gate[tgt] = 1'b0;
        m_last = tgt;
      end
    end else begin
      if (tgt >= 0) gap = 1'b1;
      else begin
        for (int k = order.size() - 1; k >= 0; k--)
          if (!m_gate[order[k]] && tgt < 0) tgt = order[k];
        if (tgt < 0) begin
          tgt = order[order.size() - 1];
          gap = 1'b1;
          steal = 1'b1;
        end
      end
      m_note[tgt] = note;
      m_last = tgt;
      m_gate[tgt] = !gap;
      for (int k = 0; k < order.size(); k++) if (order[k] == tgt) pos = k;
      order.delete(pos);
      order.push_front(tgt);
    end
    chk(32'(stolen), 32'(steal), "stolen_decide");
    check_state("decide");
    if (gap) begin
      chk(32'(ev_ready), 0, "ready_gap");
      if (abort) begin
        rst_n = 1'b0;
        ev_valid = 1'b0;
        #1;
        model_reset();
        check_state("reset_gap");
        chk(32'(stolen), 0, "reset_gap_stolen");
        chk(32'(ev_ready), 1, "reset_gap_ready");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        for (int w = 0; w < gap_wait; w++) begin
          @(negedge clk);
          chk(32'(stolen), 0, "stolen_gap");
          chk(32'(ev_ready), 0, "ready_gap_wait");
          check_state("gap_hold");
        end
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        ev_valid = 1'b0;
        m_gate[tgt] = 1'b1;
        chk(32'(stolen), 0, "stolen_after_tick");
        chk(32'(ev_ready), 1, "ready_after_tick");
        check_state("regate");
      end
    end else begin
      ev_valid = 1'b0;
      chk(32'(ev_ready), 1, "ready_after_decide");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk(32'(gate), 0, "rst_gate");
    chk(32'(voice_note), 0, "rst_note");
    chk(32'(stolen), 0, "rst_stolen");
    chk(32'(last_voice), 0, "rst_last");
    rst_n = 1'b1;
    @(negedge clk);
    chk(32'(ev_ready), 1, "rst_ready");

    // Fresh allocation into voices 0..3
    send(1, 60, 0, 0, 0);
    send(1, 62, 0, 0, 0);
    send(1, 64, 0, 0, 0);
    send(1, 65, 0, 0, 0);
    chk(32'(gate), 32'hF, "fresh_all_gated");
    chk(32'(voice_note), {7'd65, 7'd64, 7'd62, 7'd60}, "fresh_notes");

    // Steal the oldest voice; a tick in the decide cycle must not re-gate
    send(1, 67, 1, 2, 0);
    chk(32'(last_voice), 0, "steal_voice0");
    chk(32'(voice_note[6:0]), 67, "steal_note67");

    // Prefer the oldest free voice
    do_reset();
    send(1, 60, 0, 0, 0);
    send(1, 62, 0, 0, 0);
    send(1, 64, 0, 0, 0);
    send(1, 65, 0, 0, 0);
    send(0, 62, 0, 0, 0);
    send(0, 60, 0, 0, 0);
    send(1, 70, 0, 0, 0);
    chk(32'(last_voice), 0, "oldest_free_voice0");
    chk(32'(gate), 32'hD, "oldest_free_gates");

    // Retrigger 64 on voice 2
    send(1, 64, 0, 1, 0);
    chk(32'(last_voice), 2, "retrig_voice2");

    // Unmatched note-off
    send(0, 99, 0, 0, 0);
    chk(32'(gate), 32'hD, "unmatched_gates");

    // Reset during the gap of a retrigger
    send(1, 65, 0, 0, 1);
    send(1, 50, 0, 0, 0);
    chk(32'(last_voice), 0, "after_reset_voice0");

    // Random events, including note 0 and unmatched note-offs
    for (int n = 0; n < 300; n++) begin
      int note;
      bit on;
      on = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 7))
        0:       note = 0;
        1:       note = 127;
        default: note = 60 + $urandom_range(0, 6);
      endcase
      send(on, note, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
